// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/flush controller: FSM state encoding,
// scoreboard entry layout and the hard-wired zero register specifier.
package pipe_ctrl_pkg;

    localparam int SB_ADDR_W = 5;

    localparam logic [SB_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    typedef struct packed {
        logic                 v;
        logic [SB_ADDR_W-1:0] dst;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight destination registers, with source
// match logic and redirect squash of the slots younger than the redirecting one.
module hazard_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W    = 5,
    parameter int PIPE_DEPTH    = 5,
    parameter int REDIRECT_SLOT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_dst,
    input  logic                  squash,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    output logic                  match_rs,
    output logic                  match_rt
);

    sb_entry_t sb_q [PIPE_DEPTH];
    sb_entry_t sb_d [PIPE_DEPTH];

    always_comb begin
        sb_d[0] = push ? sb_entry_t'{v: 1'b1, dst: push_dst} : '0;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            sb_d[i] = sb_q[i-1];
            // Younger slots are killed as they shift past the redirecting instruction.
            if (squash && (i <= REDIRECT_SLOT)) begin
                sb_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                sb_q[i] <= sb_d[i];
            end
        end
    end

    // The oldest slot is excluded: the register file writes in the first half-cycle.
    always_comb begin
        match_rs = 1'b0;
        match_rt = 1'b0;
        for (int i = 0; i < PIPE_DEPTH - 1; i++) begin
            if (sb_q[i].v && (sb_q[i].dst == rs)) match_rs = 1'b1;
            if (sb_q[i].v && (sb_q[i].dst == rt)) match_rt = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and flush controller: stalls the front end on RAW hazards against the
// scoreboard and bubbles it for a programmable number of cycles after a redirect.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W    = 5,
    parameter int PIPE_DEPTH    = 5,
    parameter int REDIRECT_SLOT = 3,
    parameter int FLUSH_CYCLES  = 2,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  redirect,
    output logic                  pc_we,
    output logic                  ifid_we,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic [PIPE_DEPTH-1:0] squash_mask,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int                    FC_W        = 4;
    localparam logic [FC_W-1:0]       FLUSH_LOAD  = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [PIPE_DEPTH-1:0] SQUASH_BITS = PIPE_DEPTH'((64'd1 << REDIRECT_SLOT) - 64'd1);

    if (REG_ADDR_W != SB_ADDR_W || FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_param_check
        $error("pipe_hazard_ctrl: unsupported REG_ADDR_W or FLUSH_CYCLES");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    state_e           state_q, state_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             issue, stall_inc, flush_inc;
    logic             match_rs, match_rt, hazard, push;

    assign hazard = id_valid & ((id_uses_rs & (id_rs != REG_ZERO) & match_rs) |
                                (id_uses_rt & (id_rt != REG_ZERO) & match_rt));
    assign push   = issue & id_reg_write & (id_rd != REG_ZERO);

    hazard_scoreboard #(
        .REG_ADDR_W   (REG_ADDR_W),
        .PIPE_DEPTH   (PIPE_DEPTH),
        .REDIRECT_SLOT(REDIRECT_SLOT)
    ) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .push_dst(id_rd),
        .squash  (redirect),
        .rs      (id_rs),
        .rt      (id_rt),
        .match_rs(match_rs),
        .match_rt(match_rt)
    );

    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        squash_mask = '0;
        issue       = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        // Reset outputs must appear without waiting for a clock edge.
        if (!rst_n) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (redirect) begin
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            squash_mask = SQUASH_BITS;
            flush_inc   = 1'b1;
            state_d     = FLUSH;
            fcnt_d      = FLUSH_LOAD;
        end else begin
            case (state_q)
                RUN: begin
                    if (hazard) begin
                        idex_bubble = 1'b1;
                        stall_inc   = 1'b1;
                    end else begin
                        pc_we   = 1'b1;
                        ifid_we = 1'b1;
                        issue   = id_valid;
                    end
                end
                FLUSH: begin
                    pc_we       = 1'b1;
                    ifid_we     = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (fcnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        fcnt_d = fcnt_q - 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            if (stall_inc) stall_q <= sat_inc(stall_q);
            if (flush_inc) flush_q <= sat_inc(flush_q);
        end
    end

    assign stall_count = stall_q;
    assign flush_count = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table for stall/no-stall cases,
// hand-written sequences for redirect, flush extension and asynchronous reset.
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;
    localparam int PD = 5;
    localparam int CW = 16;

    // {pc_we, ifid_we, ifid_flush, idex_bubble, squash_mask}
    localparam logic [8:0] RUNO   = 9'b1100_00000;
    localparam logic [8:0] STALLO = 9'b0001_00000;
    localparam logic [8:0] FLUSHO = 9'b1111_00000;
    localparam logic [8:0] RSTO   = 9'b0011_00000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic          id_uses_rs, id_uses_rt, id_reg_write, redirect;
    logic          pc_we, ifid_we, ifid_flush, idex_bubble;
    logic [PD-1:0] squash_mask;
    logic [CW-1:0] stall_count, flush_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .id_rd       (id_rd),
        .id_reg_write(id_reg_write),
        .redirect    (redirect),
        .pc_we       (pc_we),
        .ifid_we     (ifid_we),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .squash_mask (squash_mask),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    typedef struct {
        logic          v;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic          urs;
        logic          urt;
        logic [AW-1:0] rd;
        logic          rw;
        logic          redir;
        logic [8:0]    exp;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                                input logic urs, input logic urt, input logic [AW-1:0] rd,
                                input logic rw, input logic redir, input logic [8:0] exp);
        vec_t r;
        r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
        r.rd = rd; r.rw = rw; r.redir = redir; r.exp = exp;
        return r;
    endfunction

    function automatic logic [8:0] outs();
        return {pc_we, ifid_we, ifid_flush, idex_bubble, squash_mask};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic urs, input logic urt, input logic [AW-1:0] rd,
                         input logic rw, input logic redir);
        @(negedge clk);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_rd = rd; id_reg_write = rw; redirect = redir;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        //              v  rs  rt  urs urt rd  rw redir exp
        tbl[0]  = mk(1, 1,  2,  1,  1,  3,  1,  0,  RUNO);
        tbl[1]  = mk(1, 6,  7,  1,  1,  4,  1,  0,  RUNO);
        tbl[2]  = mk(1, 1,  2,  1,  1,  5,  1,  0,  RUNO);
        tbl[3]  = mk(1, 5,  0,  1,  0,  0,  0,  0,  STALLO);
        tbl[4]  = mk(1, 5,  0,  1,  0,  0,  0,  0,  STALLO);
        tbl[5]  = mk(1, 5,  0,  1,  0,  0,  0,  0,  STALLO);
        tbl[6]  = mk(1, 5,  0,  1,  0,  0,  0,  0,  STALLO);
        tbl[7]  = mk(1, 5,  0,  1,  0,  0,  0,  0,  RUNO);
        tbl[8]  = mk(1, 1,  2,  0,  0,  0,  1,  0,  RUNO);
        tbl[9]  = mk(1, 0,  0,  1,  1,  0,  0,  0,  RUNO);
        tbl[10] = mk(1, 1,  2,  0,  0,  5,  0,  0,  RUNO);
        tbl[11] = mk(1, 5,  0,  1,  0,  0,  0,  0,  RUNO);
        tbl[12] = mk(1, 1,  2,  0,  0,  6,  1,  0,  RUNO);
        tbl[13] = mk(1, 6,  6,  0,  0,  0,  0,  0,  RUNO);
        tbl[14] = mk(1, 0,  6,  0,  1,  0,  0,  0,  STALLO);
        tbl[15] = mk(0, 0,  6,  0,  1,  0,  0,  0,  RUNO);
        tbl[16] = mk(0, 0,  0,  0,  0,  0,  0,  0,  RUNO);

        rst_n = 1'b0;
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_rd = '0; id_reg_write = 1'b0; redirect = 1'b0;
        #1;
        check("reset_outs", 32'(outs()), 32'(RSTO));
        check("reset_stall_count", 32'(stall_count), 32'd0);
        check("reset_flush_count", 32'(flush_count), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt,
                  tbl[i].rd, tbl[i].rw, tbl[i].redir);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
            if (i == 7) check("stall_count_raw", 32'(stall_count), 32'd4);
        end
        idle();
        check("stall_count_table", 32'(stall_count), 32'd5);
        check("flush_count_table", 32'(flush_count), 32'd0);

        // Redirect squashes three issued writers
        repeat (3) idle();
        drive(1, 0, 0, 0, 0, 5'd1, 1, 0);
        drive(1, 0, 0, 0, 0, 5'd2, 1, 0);
        drive(1, 0, 0, 0, 0, 5'd3, 1, 0);
        check("writer3_outs", 32'(outs()), 32'(RUNO));
        drive(1, 0, 0, 0, 0, 5'd4, 1, 1);
        check("redir_pc_we", 32'(pc_we), 32'd1);
        check("redir_ifid_flush", 32'(ifid_flush), 32'd1);
        check("redir_idex_bubble", 32'(idex_bubble), 32'd1);
        check("redir_squash_mask", 32'(squash_mask), 32'h07);
        drive(1, 5'd3, 5'd2, 1, 1, 0, 0, 0);
        check("flushA_0", 32'(outs()), 32'(FLUSHO));
        check("flush_count_A", 32'(flush_count), 32'd1);
        drive(1, 5'd3, 5'd2, 1, 1, 0, 0, 0);
        check("flushA_1", 32'(outs()), 32'(FLUSHO));
        drive(1, 5'd3, 5'd2, 1, 1, 0, 0, 0);
        check("afterA_squashed_no_stall", 32'(outs()), 32'(RUNO));
        drive(1, 5'd3, 5'd2, 1, 1, 0, 0, 0);
        check("afterA_run", 32'(outs()), 32'(RUNO));

        // Redirect and hazard together, then a redirect while flushing
        drive(1, 0, 0, 0, 0, 5'd7, 1, 0);
        check("prodB_outs", 32'(outs()), 32'(RUNO));
        drive(1, 5'd7, 0, 1, 0, 0, 0, 1);
        check("redir_hazard_pc_we", 32'(pc_we), 32'd1);
        check("redir_hazard_bubble", 32'(idex_bubble), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        check("redir_in_flush_ifid_flush", 32'(ifid_flush), 32'd1);
        check("redir_in_flush_mask", 32'(squash_mask), 32'h07);
        check("stall_unchanged_B", 32'(stall_count), 32'd5);
        check("flush_count_B1", 32'(flush_count), 32'd2);
        idle();
        check("flushB_0", 32'(outs()), 32'(FLUSHO));
        check("flush_count_B2", 32'(flush_count), 32'd3);
        idle();
        check("flushB_1_extended", 32'(outs()), 32'(FLUSHO));
        idle();
        check("afterB_run", 32'(outs()), 32'(RUNO));

        // Asynchronous reset in the middle of a flush
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        check("flushC_0", 32'(outs()), 32'(FLUSHO));
        #2;
        rst_n = 1'b0;
        redirect = 1'b1;
        #1;
        check("midflush_reset_outs", 32'(outs()), 32'(RSTO));
        check("midflush_reset_stall", 32'(stall_count), 32'd0);
        check("midflush_reset_flush", 32'(flush_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        redirect = 1'b0;
        #1;
        check("after_flush_reset_run", 32'(outs()), 32'(RUNO));

        // Asynchronous reset in the middle of a stall
        drive(1, 0, 0, 0, 0, 5'd9, 1, 0);
        drive(1, 5'd9, 0, 1, 0, 0, 0, 0);
        check("stallD", 32'(outs()), 32'(STALLO));
        #2;
        rst_n = 1'b0;
        #1;
        check("midstall_reset_outs", 32'(outs()), 32'(RSTO));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("after_stall_reset_sb_empty", 32'(outs()), 32'(RUNO));
        idle();
        check("after_stall_reset_stall", 32'(stall_count), 32'd0);
        check("after_stall_reset_flush", 32'(flush_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
